// File: rtl/dfc_arbiter.sv
// Two-host round-robin arbiter and sequencer for a shared DFC compute unit.
// One host at a time owns the DFC. The owner's command is issued, then either
// its load bytes are streamed in or the result beats are routed back to it.
module dfc_arbiter #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 9,
  parameter int LOAD_LEN  = 8,
  parameter int STORE_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h0_req,
  input  logic [1:0]        h0_cmd,
  input  logic [DATA_W-1:0] h0_datain,
  output logic              h0_gnt,
  output logic              h0_rd,
  output logic              h0_out_valid,
  output logic              h0_err,
  input  logic              h1_req,
  input  logic [1:0]        h1_cmd,
  input  logic [DATA_W-1:0] h1_datain,
  output logic              h1_gnt,
  output logic              h1_rd,
  output logic              h1_out_valid,
  output logic              h1_err,
  output logic [OUT_W-1:0]  dout,
  output logic [1:0]        dfc_cmd,
  output logic              dfc_cmd_valid,
  output logic [DATA_W-1:0] dfc_datain,
  input  logic              dfc_busy,
  input  logic              dfc_output_valid,
  input  logic [OUT_W-1:0]  dfc_dataout
);

  localparam int MAX_LEN = (LOAD_LEN > STORE_LEN) ? LOAD_LEN : STORE_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [1:0] CMD_LOAD    = 2'b00;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic              owner;
  logic              last_served;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        own_cmd;
  logic [DATA_W-1:0] own_datain;
  logic              pick;
  logic              any_req;
  logic              busy_phase;

  // Owner-selected host signals and the round-robin pick for the next grant.
  always_comb begin
    own_cmd    = owner ? h1_cmd    : h0_cmd;
    own_datain = owner ? h1_datain : h0_datain;
    any_req    = h0_req | h1_req;
    // On a tie the host that was not served last wins; otherwise the lone requester.
    pick       = (h0_req && h1_req) ? ~last_served : h1_req;
  end

  // Sequencer: grant, issue command, then stream load bytes or count result beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!dfc_busy && any_req) begin
            owner       <= pick;
            last_served <= pick;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (own_cmd == CMD_ILLEGAL)   state <= IDLE;
          else if (own_cmd == CMD_LOAD) state <= LOAD;
          else                          state <= DRAIN;
        end
        LOAD: begin
          if (cnt == CNT_W'(LOAD_LEN - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (dfc_output_valid) begin
            if (cnt == CNT_W'(STORE_LEN - 1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state/owner; DFC strobes gated by phase.
  always_comb begin
    busy_phase    = (state != IDLE);
    h0_gnt        = busy_phase && !owner;
    h1_gnt        = busy_phase &&  owner;
    h0_rd         = (state == LOAD) && !owner;
    h1_rd         = (state == LOAD) &&  owner;
    h0_out_valid  = (state == DRAIN) && !owner && dfc_output_valid;
    h1_out_valid  = (state == DRAIN) &&  owner && dfc_output_valid;
    h0_err        = (state == ISSUE) && !owner && (own_cmd == CMD_ILLEGAL);
    h1_err        = (state == ISSUE) &&  owner && (own_cmd == CMD_ILLEGAL);
    dfc_cmd_valid = (state == ISSUE) && (own_cmd != CMD_ILLEGAL);
    dfc_cmd       = dfc_cmd_valid ? own_cmd : 2'b00;
    dfc_datain    = (state == LOAD) ? own_datain : '0;
    dout          = dfc_dataout;
  end

endmodule

// File: tb/tb_dfc_arbiter.sv
// Directed bench for dfc_arbiter: per-cycle vector table plus a reset sequence.
module tb_dfc_arbiter;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              h0_req = 1'b0, h1_req = 1'b0;
  logic [1:0]        h0_cmd = 2'b00, h1_cmd = 2'b00;
  logic [DATA_W-1:0] h0_datain = '0, h1_datain = '0;
  logic              h0_gnt, h0_rd, h0_out_valid, h0_err;
  logic              h1_gnt, h1_rd, h1_out_valid, h1_err;
  logic [OUT_W-1:0]  dout;
  logic [1:0]        dfc_cmd;
  logic              dfc_cmd_valid;
  logic [DATA_W-1:0] dfc_datain;
  logic              dfc_busy = 1'b0;
  logic              dfc_output_valid = 1'b0;
  logic [OUT_W-1:0]  dfc_dataout = '0;

  dfc_arbiter #(.DATA_W(DATA_W), .OUT_W(OUT_W), .LOAD_LEN(8), .STORE_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .h0_req(h0_req), .h0_cmd(h0_cmd), .h0_datain(h0_datain),
    .h0_gnt(h0_gnt), .h0_rd(h0_rd), .h0_out_valid(h0_out_valid), .h0_err(h0_err),
    .h1_req(h1_req), .h1_cmd(h1_cmd), .h1_datain(h1_datain),
    .h1_gnt(h1_gnt), .h1_rd(h1_rd), .h1_out_valid(h1_out_valid), .h1_err(h1_err),
    .dout(dout), .dfc_cmd(dfc_cmd), .dfc_cmd_valid(dfc_cmd_valid), .dfc_datain(dfc_datain),
    .dfc_busy(dfc_busy), .dfc_output_valid(dfc_output_valid), .dfc_dataout(dfc_dataout)
  );

  always #5 clk = ~clk;

  // One cycle: host inputs, DFC inputs, and the outputs required in that cycle.
  // fl = {h0_gnt,h0_rd,h0_out_valid,h0_err,h1_gnt,h1_rd,h1_out_valid,h1_err}
  typedef struct {
    logic [2:0]        h0;   // {req, cmd}
    logic [DATA_W-1:0] d0;
    logic [2:0]        h1;
    logic [DATA_W-1:0] d1;
    logic              busy;
    logic              ov;
    logic [OUT_W-1:0]  dio;
    logic [7:0]        fl;
    logic              cv;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] din;
  } vec_t;

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] G0   = 8'b1000_0000;
  localparam logic [7:0] RD0  = 8'b1100_0000;
  localparam logic [7:0] OV0  = 8'b1010_0000;
  localparam logic [7:0] ER0  = 8'b1001_0000;
  localparam logic [7:0] G1   = 8'b0000_1000;
  localparam logic [7:0] OV1  = 8'b0000_1010;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  logic [7:0] ld_bytes [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20, 8'd30, 8'd40};
  logic [8:0] results  [4] = '{9'd11, 9'd22, 9'd33, 9'd44};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [2:0] h0, input logic [7:0] d0,
                             input logic [2:0] h1, input logic [7:0] d1,
                             input logic busy, input logic ov, input logic [8:0] dio,
                             input logic [7:0] fl, input logic cv, input logic [1:0] cmd,
                             input logic [7:0] din);
    vec_t r;
    r.h0 = h0; r.d0 = d0; r.h1 = h1; r.d1 = d1; r.busy = busy; r.ov = ov; r.dio = dio;
    r.fl = fl; r.cv = cv; r.cmd = cmd; r.din = din;
    return r;
  endfunction

  function automatic logic [7:0] flags_now();
    return {h0_gnt, h0_rd, h0_out_valid, h0_err, h1_gnt, h1_rd, h1_out_valid, h1_err};
  endfunction

  // Drive one vector just after a rising edge, check at the falling edge.
  task automatic apply(input vec_t x, input int idx);
    {h0_req, h0_cmd} = x.h0; h0_datain = x.d0;
    {h1_req, h1_cmd} = x.h1; h1_datain = x.d1;
    dfc_busy = x.busy; dfc_output_valid = x.ov; dfc_dataout = x.dio;
    @(negedge clk);
    chk($sformatf("v%0d_flags", idx), 16'(flags_now()), 16'(x.fl));
    chk($sformatf("v%0d_cmd_valid", idx), 16'(dfc_cmd_valid), 16'(x.cv));
    chk($sformatf("v%0d_cmd", idx), 16'(dfc_cmd), 16'(x.cmd));
    chk($sformatf("v%0d_datain", idx), 16'(dfc_datain), 16'(x.din));
    chk($sformatf("v%0d_dout", idx), 16'(dout), 16'(x.dio));
    @(posedge clk); #1;
  endtask

  // Both hosts request a FIFO read; 'fl_g' and 'fl_o' name the expected winner.
  task automatic rr_txn(input logic [7:0] fl_g, input logic [7:0] fl_o, input logic [2:0] h1_after);
    vq.push_back(v(3'b101, 0, 3'b101, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b101, 0, 3'b101, 0, 0, 0, 0, fl_g, 1, 2'b01, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(3'b101, 0, h1_after, 0, 0, 1, 9'(100 + k), fl_o, 0, 2'b00, 0));
  endtask

  initial begin
    // Scenario 1a: host0 load of 1,2,3,4,10,20,30,40.
    vq.push_back(v(3'b100, 0, 3'b000, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b100, 0, 3'b000, 0, 0, 0, 0, G0, 1, 2'b00, 0));
    for (int k = 0; k < 8; k++)
      vq.push_back(v(3'b000, ld_bytes[k], 3'b000, 8'hEE, 0, 0, 0, RD0, 0, 2'b00, ld_bytes[k]));
    vq.push_back(v(3'b000, 8'h77, 3'b000, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    // Scenario 1b: host0 FIFO readout 11,22,33,44.
    vq.push_back(v(3'b101, 0, 3'b000, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b101, 0, 3'b000, 0, 0, 0, 0, G0, 1, 2'b01, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 1, results[k], OV0, 0, 2'b00, 0));
    // Scenario 6: output_valid while IDLE reaches nobody, no grant follows.
    vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 1, 9'd5, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 1, 9'd6, NONE, 0, 2'b00, 0));
    // Scenario 2: host1 LIFO readout 44,33,22,11; host0 sees nothing.
    vq.push_back(v(3'b000, 0, 3'b110, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b000, 0, 3'b110, 0, 0, 0, 0, G1, 1, 2'b10, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 1, results[3 - k], OV1, 0, 2'b00, 0));
    // DFC busy in IDLE: both requests held, no grant.
    vq.push_back(v(3'b101, 0, 3'b101, 0, 1, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b101, 0, 3'b101, 0, 1, 0, 0, NONE, 0, 2'b00, 0));
    // Scenario 3: both held, grants alternate h0, h1, h0, h1.
    rr_txn(G0, OV0, 3'b101);
    rr_txn(G1, OV1, 3'b101);
    rr_txn(G0, OV0, 3'b101);
    rr_txn(G1, OV1, 3'b000);
    // Scenario 4: host0 illegal cmd, pending host1 served right after.
    vq.push_back(v(3'b111, 0, 3'b101, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b111, 0, 3'b101, 0, 0, 0, 0, ER0, 0, 2'b00, 0));
    vq.push_back(v(3'b000, 0, 3'b101, 0, 0, 0, 0, NONE, 0, 2'b00, 0));
    vq.push_back(v(3'b000, 0, 3'b101, 0, 0, 0, 0, G1, 1, 2'b01, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 1, 9'(200 + k), OV1, 0, 2'b00, 0));
    vq.push_back(v(3'b000, 0, 3'b000, 0, 0, 0, 0, NONE, 0, 2'b00, 0));

    // Reset state.
    @(negedge clk);
    chk("rst_flags", 16'(flags_now()), 16'h0);
    chk("rst_cmd_valid", 16'(dfc_cmd_valid), 16'h0);
    chk("rst_datain", 16'(dfc_datain), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vq[i]) apply(vq[i], i);

    // Scenario 5: reset during load beat 3, then host1 load.
    h0_req = 1'b1; h0_cmd = 2'b00;
    @(posedge clk); #1;                 // ISSUE
    h0_req = 1'b0; h0_datain = 8'h33;
    @(posedge clk); #1;                 // beat 1
    @(posedge clk); #1;                 // beat 2
    @(posedge clk); #1;                 // beat 3
    chk("s5_rd_before", 16'(h0_rd), 16'h1);
    chk("s5_din_before", 16'(dfc_datain), 16'h33);
    reset = 1'b1;
    #1;
    chk("s5_async_flags", 16'(flags_now()), 16'h0);
    chk("s5_async_datain", 16'(dfc_datain), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    h1_req = 1'b1; h1_cmd = 2'b00; h1_datain = 8'h5A;
    @(negedge clk);
    chk("s5_t0_flags", 16'(flags_now()), 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s5_t1_flags", 16'(flags_now()), 16'(G1));
    chk("s5_t1_cmd_valid", 16'(dfc_cmd_valid), 16'h1);
    @(posedge clk); #1;
    h1_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      h1_datain = 8'(8'h60 + k);
      @(negedge clk);
      chk($sformatf("s5_beat%0d_flags", k), 16'(flags_now()), 16'b0000_1100);
      chk($sformatf("s5_beat%0d_din", k), 16'(dfc_datain), 16'(8'h60 + k));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("s5_idle_flags", 16'(flags_now()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
